// File: rtl/game_referee_if.sv
// Move handshakes, run controls and result signals shared by the referee and its environment.
// The referee takes the slave modport; the environment (agent, player, learner) takes master.
interface game_referee_if #(
   parameter int N     = 3,
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
);
   logic               enable;
   logic               first_mover;
   logic               agent_valid;
   logic [IDX_W-1:0]   agent_action;
   logic               agent_ready;
   logic               player_valid;
   logic [IDX_W-1:0]   player_action;
   logic               player_ready;
   logic [2*N*N-1:0]   board;
   logic [1:0]         outcome;
   logic               outcome_valid;
   logic               illegal_move;
   logic               rst_policygen;
   logic [CNT_W-1:0]   game_count;

   modport master (
      output enable, first_mover, agent_valid, agent_action, player_valid, player_action,
      input  agent_ready, player_ready, board, outcome, outcome_valid, illegal_move,
             rst_policygen, game_count
   );

   modport slave (
      input  enable, first_mover, agent_valid, agent_action, player_valid, player_action,
      output agent_ready, player_ready, board, outcome, outcome_valid, illegal_move,
             rst_policygen, game_count
   );
endinterface

// File: rtl/game_referee.sv
// N x N, K-in-a-row referee: alternates agent/player moves, rejects illegal ones, reports results.
// Move at t -> board at t+1 -> outcome at t+2; only the side on turn sees ready, the other is ignored.
module game_referee #(
   parameter int N          = 3,
   parameter int K          = 3,
   parameter int IDX_W      = 4,
   parameter int GAME_LIMIT = 100,
   parameter int CNT_W      = 16
) (
   input  logic         clock,
   input  logic         rst_n,
   game_referee_if.slave bus
);
   localparam int NCELL = N * N;
   localparam int BW    = 2 * NCELL;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AGENT,
      S_PLAYER,
      S_EVAL,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [BW-1:0]    board_q, board_d;
   logic             mover_q, mover_d;
   logic [1:0]       outcome_q, outcome_d;
   logic             outcome_valid_q, outcome_valid_d;
   logic             illegal_q, illegal_d;
   logic             rst_pg_q, rst_pg_d;
   logic [CNT_W-1:0] game_count_q, game_count_d;

   logic             mv_vld;
   logic [IDX_W-1:0] mv_act;
   logic [1:0]       mv_pat;
   logic [1:0]       eval_pat;

   // Out-of-range indices read as occupied, so one compare covers both legality rules.
   function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input logic [IDX_W-1:0] idx);
      cell_at = 2'b11;
      if (int'(idx) < NCELL) cell_at = 2'(b >> (2 * idx));
   endfunction

   function automatic logic [1:0] cell_rc(input logic [BW-1:0] b, input int r, input int c);
      cell_rc = 2'b11;
      if (r >= 0 && r < N && c >= 0 && c < N) cell_rc = 2'(b >> (2 * (r * N + c)));
   endfunction

   function automatic logic [BW-1:0] put_cell(input logic [BW-1:0] b, input logic [IDX_W-1:0] idx,
                                              input logic [1:0] p);
      put_cell = (b & ~(BW'(2'b11) << (2 * idx))) | (BW'(p) << (2 * idx));
   endfunction

   function automatic logic has_run(input logic [BW-1:0] b, input logic [1:0] p);
      logic found, rh, rv, rd, ra;
      found = 1'b0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            rh = (c + K <= N);
            rv = (r + K <= N);
            rd = rh && rv;
            ra = rv && (c >= K - 1);
            for (int i = 0; i < K; i++) begin
               if (cell_rc(b, r, c + i) != p)     rh = 1'b0;
               if (cell_rc(b, r + i, c) != p)     rv = 1'b0;
               if (cell_rc(b, r + i, c + i) != p) rd = 1'b0;
               if (cell_rc(b, r + i, c - i) != p) ra = 1'b0;
            end
            found = found | rh | rv | rd | ra;
         end
      end
      has_run = found;
   endfunction

   function automatic logic is_full(input logic [BW-1:0] b);
      is_full = 1'b1;
      for (int i = 0; i < NCELL; i++) begin
         if (2'(b >> (2 * i)) == 2'b00) is_full = 1'b0;
      end
   endfunction

   assign bus.agent_ready  = bus.enable && (state_q == S_AGENT);
   assign bus.player_ready = bus.enable && (state_q == S_PLAYER);

   always_comb begin
      mv_vld   = (bus.agent_ready && bus.agent_valid) || (bus.player_ready && bus.player_valid);
      mv_act   = (state_q == S_PLAYER) ? bus.player_action : bus.agent_action;
      mv_pat   = (state_q == S_PLAYER) ? 2'b10 : 2'b01;
      eval_pat = mover_q ? 2'b10 : 2'b01;
   end

   always_comb begin
      state_d         = state_q;
      board_d         = board_q;
      mover_d         = mover_q;
      outcome_d       = outcome_q;
      outcome_valid_d = 1'b0;
      illegal_d       = 1'b0;
      rst_pg_d        = 1'b0;
      game_count_d    = game_count_q;

      if (!bus.enable) begin
         state_d = S_IDLE;
         board_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = bus.first_mover ? S_PLAYER : S_AGENT;
            end
            S_AGENT, S_PLAYER: begin
               if (mv_vld) begin
                  if (cell_at(board_q, mv_act) == 2'b00) begin
                     board_d = put_cell(board_q, mv_act, mv_pat);
                     mover_d = (state_q == S_PLAYER);
                     state_d = S_EVAL;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
            end
            S_EVAL: begin
               // A win on the last free cell is reported as a win, not a draw.
               if (has_run(board_q, eval_pat)) begin
                  outcome_d       = eval_pat;
                  outcome_valid_d = 1'b1;
                  state_d         = S_DONE;
               end else if (is_full(board_q)) begin
                  outcome_d       = 2'b11;
                  outcome_valid_d = 1'b1;
                  state_d         = S_DONE;
               end else begin
                  state_d = mover_q ? S_AGENT : S_PLAYER;
               end
            end
            S_DONE: begin
               board_d = '0;
               if (game_count_q == CNT_W'(GAME_LIMIT - 1)) begin
                  game_count_d = '0;
                  rst_pg_d     = 1'b1;
               end else begin
                  game_count_d = game_count_q + 1'b1;
               end
               state_d = bus.first_mover ? S_PLAYER : S_AGENT;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         board_q         <= '0;
         mover_q         <= 1'b0;
         outcome_q       <= 2'b00;
         outcome_valid_q <= 1'b0;
         illegal_q       <= 1'b0;
         rst_pg_q        <= 1'b0;
         game_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         board_q         <= board_d;
         mover_q         <= mover_d;
         outcome_q       <= outcome_d;
         outcome_valid_q <= outcome_valid_d;
         illegal_q       <= illegal_d;
         rst_pg_q        <= rst_pg_d;
         game_count_q    <= game_count_d;
      end
   end

   assign bus.board         = board_q;
   assign bus.outcome       = outcome_q;
   assign bus.outcome_valid = outcome_valid_q;
   assign bus.illegal_move  = illegal_q;
   assign bus.rst_policygen = rst_pg_q;
   assign bus.game_count    = game_count_q;
endmodule

// File: doc/game_referee.md
Name: game_referee

Overview:
- Parametrised N×N, K-in-a-row board referee for the self-play learning loop.
- Successor to the fixed 3×3 control unit. Adds alternating agent/player turns with valid/ready handshakes, illegal-move rejection, a selectable first mover, a registered outcome strobe, and a game counter that pulses rst_policygen every GAME_LIMIT games.
- Sits between the policy generator (agent side), the opponent/player source, and the reward/learning logic.

Parameters:
- N, 3, board side length; N*N cells, 2 bits per cell (00 empty, 01 agent, 10 player, 11 unused).
- K, 3, run length that wins; 2 ≤ K ≤ N.
- IDX_W, 4, width of the action index; 2^IDX_W ≥ N*N is required.
- GAME_LIMIT, 100, completed games per rst_policygen pulse; ≥ 1.
- CNT_W, 16, width of game_count.

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  synchronous run enable; low returns the block to IDLE and clears the board.
- first_mover  in  1  0 = agent opens, 1 = player opens; sampled when each game starts.
- agent_valid  in  1  agent move offered.
- agent_action  in  IDX_W  agent cell index, row-major (cell = row*N + col).
- agent_ready  out  1  high only in AGENT_TURN.
- player_valid  in  1  player move offered.
- player_action  in  IDX_W  player cell index.
- player_ready  out  1  high only in PLAYER_TURN.
- board  out  2*N*N  current board; cell i occupies bits [2i+1:2i].
- outcome  out  2  01 agent win, 10 player win, 11 draw, 00 none; held until the next game ends.
- outcome_valid  out  1  one-cycle strobe when outcome updates.
- illegal_move  out  1  one-cycle strobe when a rejected move is accepted.
- rst_policygen  out  1  one-cycle pulse when game_count wraps.
- game_count  out  CNT_W  completed games modulo GAME_LIMIT.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, board 0, outcome 00, game_count 0; all strobes 0, both readys 0.
- enable low (synchronous, overrides everything): state IDLE, board 0, strobes 0. outcome and game_count hold.
- States: IDLE, AGENT_TURN, PLAYER_TURN, EVAL, DONE.
- IDLE → AGENT_TURN if first_mover = 0, else PLAYER_TURN, on the first cycle enable is high.
- Move handshake:
  - A move transfers when valid && ready are both high in the same cycle.
  - The side that is not on turn sees ready = 0; its valid is ignored and no strobe is raised, even if both valids are high together.
- Legality: a move is legal if action < N*N and the target cell is 00.
  - Legal move: the cell is written (01 agent, 10 player) and visible on board the next cycle; state → EVAL, remembering who moved.
  - Illegal move: board unchanged; illegal_move pulses the next cycle; state stays on the same turn, so ready remains high.
- EVAL (one cycle): win/draw logic reads the registered board.
  - Win check covers every horizontal, vertical, diagonal and anti-diagonal run of K consecutive cells.
  - Only the side that just moved is checked.
  - Win: outcome = 01/10. Else if no empty cell: outcome = 11. Either result → DONE with outcome_valid = 1 registered.
  - Otherwise → the opponent's turn, outcome unchanged.
- Latency: move accepted at cycle t → board updated at t+1 → outcome/outcome_valid visible at t+2. The next turn's ready is high at t+2 when there is no result.
- DONE (one cycle): board cleared, game_count incremented.
  - If game_count = GAME_LIMIT−1, it wraps to 0 and rst_policygen pulses in the same registered cycle.
  - first_mover is resampled; state → AGENT_TURN or PLAYER_TURN.
- Outcome priority: a win by the mover beats draw. A full-board win reports the win.
- Throughput: the minimum game is 2K−1 moves, each taking 2 cycles (turn + EVAL), plus 1 DONE cycle.
- Reset or enable drop mid-game abandons the game: no outcome_valid, no game_count increment.

Test Plan:
- N=3, K=3, first_mover=0. Agent plays 0,4,8; player plays 1,2 → outcome=01 with outcome_valid pulse 2 cycles after the agent's move 8; board=0 one cycle later; game_count=1.
- N=3. Player opens and plays 2,4,6 (anti-diagonal); agent plays 0,1 → outcome=10.
- N=3. Full-board sequence with no line → outcome=11 after the 9th move.
- Illegal moves: agent plays 4, then player plays 4, then player plays 12 → illegal_move pulses twice, board cell 4 stays 01, player_ready stays high, then player plays 5 → accepted.
- GAME_LIMIT=3, three agent wins → game_count reads 1, 2, then 0, with rst_policygen high exactly once, in the cycle game_count goes from 2 to 0.
- N=5, K=4. Agent plays row 1, cells 6..9, against scattered player moves → win. Drop rst_n mid-game in a separate run → board=0, outcome=00, no strobes.
